inst_sequencer: RTL and testbench
=================================

# inst_sequencer

Instruction register and T-state sequencer that sits directly upstream of `instdecode`. It latches opcodes from the data bus and generates the 3-bit `cycle` count. It arbitrates reset, NMI and IRQ into forced `int` (8'h00) sequences, then advances or restarts the cycle count from the decoder's `icyc`/`rcyc`/`scyc`/`sinst` feedback.

## Interface
- `INT_OP`, 8'h00: opcode injected for reset/NMI/IRQ service.
- `CYC_W`, 3: cycle counter width; `instdecode` requires 3.
- `clk` in 1: system clock; all state updates on the rising edge.
- `clr_n` in 1: reset, synchronous, active-low.
- `dbus` in 8: data bus; carries the next opcode during any cycle in which `rcyc`=1.
- `icyc` in 1: from decoder; advance to the next cycle.
- `rcyc` in 1: from decoder; instruction complete, restart at cycle 0 with a new opcode.
- `scyc` in 1: from decoder; stall, hold the current cycle.
- `sinst` in 1: from decoder; the interrupt/reset sequence has been accepted.
- `irq_in` in 1: maskable interrupt request, active-high, level.
- `nmi_in` in 1: non-maskable interrupt request, active-high, rising-edge.
- `irq_dis` in 1: status-register I flag.
- `inst` out 8: opcode to the decoder.
- `cycle` out 3: T-state to the decoder.
- `clr` out 1: reset request to the decoder.
- `irq` out 1: IRQ request to the decoder.
- `nmi` out 1: NMI request to the decoder.
- `seq_err` out 1: sticky sequencing-fault flag.

## Operation
- Reset (`clr_n`=0 at a clock edge) sets:
  - `inst`=`INT_OP`, `cycle`=0, `clr`=1;
  - `nmi_pend`=0, `nmi`=0, `irq`=0, `seq_err`=0;
  - the NMI edge-detector history = current `nmi_in`.
- Cycle update priority is `rcyc` > `scyc` > `icyc` > hold:
  - `rcyc`: `cycle`←0 and `inst` loads (see injection below).
  - `scyc`: `cycle` holds.
  - `icyc`: `cycle`←`cycle`+1.
  - none asserted: `cycle` holds.
- Wrap: `icyc` at `cycle`=7 without `rcyc` sets `cycle`←0 and `seq_err`←1. `seq_err` stays set until reset.
- Injection, evaluated on an `rcyc` edge:
  - if `clr`=1, or `nmi_pend`=1, or (`irq_in`=1 and `irq_dis`=0): `inst`←`INT_OP`;
  - otherwise: `inst`←`dbus`.
- `nmi_pend` is set on a rising edge of `nmi_in`.
- Outputs to the decoder are registered and updated only on `rcyc` edges, so they are stable for the whole instruction:
  - `nmi`←`nmi_pend`;
  - `irq`←`irq_in & ~irq_dis & ~nmi_pend`.
  - NMI outranks IRQ. `clr` outranks both because the decoder checks it first.
- Acknowledge: `sinst`=1 with `cycle`=0 and `inst`=`INT_OP`:
  - if `clr`=1: `clr`←0;
  - else if `nmi`=1: `nmi`←0 and `nmi_pend`←0, unless a new rising edge arrives in the same cycle, in which case `nmi_pend` stays 1;
  - else: `irq`←0.
- `sinst` with any other `inst` or `cycle` is ignored.
- Simultaneous `rcyc` and `icyc` (e.g. `jsr` cycle 6): `rcyc` wins and no error is flagged.

## Timing
- Opcode latency: `dbus` sampled at the `rcyc` edge; `inst`/`cycle`=0 are valid in the next cycle.
- Zero-cycle stalls are not possible. Every edge applies exactly one priority action.
- Minimum NMI-to-injection latency: one edge to set `nmi_pend`, then the next `rcyc` edge.
- An NMI edge arriving during an `int` sequence is held pending and is serviced after that sequence's `rcyc`.
- Reset mid-instruction takes effect at the next edge. All partial state is discarded.
- `irq_in` dropping before an `rcyc` edge means no injection. The level is not latched.

## Configuration
- `INST_SEQ_NMI_EN` defined:
  - NMI edge detector, `nmi_pend` and the `nmi` output are active as described above.
- `INST_SEQ_NMI_EN` undefined:
  - `nmi_in` is ignored;
  - `nmi` and `nmi_pend` are tied to 0;
  - the edge detector is not instantiated;
  - the injection condition reduces to `clr` | (`irq_in` & ~`irq_dis`).

## Structure
- Shared package `mos6502_pkg` holds:
  - `INT_OP`;
  - the cycle width constant;
  - a 3-bit cycle typedef;
  - the opcode constants shared with `instdecode`.
- One sub-module, `nmi_edge_det`: synchronous rising-edge detector that outputs a one-cycle pulse. Compiled only under `INST_SEQ_NMI_EN`.

## Test plan
- Reset and handoff: hold `clr_n`=0 for 2 cycles, then release → `inst`=8'h00, `cycle`=0, `clr`=1. Assert `sinst` → `clr`=0. Then `icyc`×7 and `rcyc` with `dbus`=8'hA9 → `inst`=8'hA9, `cycle`=0.
- Normal sequencing:
  - `icyc`, `icyc`, then `scyc` → `cycle` goes 1, 2, 2;
  - `rcyc`+`icyc` together with `dbus`=8'hEA → `cycle`=0, `inst`=8'hEA, `seq_err`=0.
- IRQ masking:
  - `irq_in`=1, `irq_dis`=1, `rcyc` with `dbus`=8'hE8 → `inst`=8'hE8, `irq`=0;
  - `irq_dis`=0, then `rcyc` → `inst`=8'h00, `irq`=1;
  - `sinst` at cycle 0 → `irq`=0.
- NMI priority: pulse `nmi_in`, hold `irq_in`=1, then `rcyc` → `inst`=8'h00, `nmi`=1, `irq`=0. `sinst` → `nmi`=0, `nmi_pend`=0.
- Wrap fault: `icyc`×8 from `cycle`=0 with no `rcyc` → `cycle`=0, `seq_err`=1. `seq_err` stays 1 until `clr_n`=0.
- Macro off (`INST_SEQ_NMI_EN` undefined): pulse `nmi_in`, then `rcyc` with `dbus`=8'h18 → `inst`=8'h18, `nmi`=0.

Source files
------------

// File: rtl/mos6502_pkg.sv
// Shared 6502 core constants: the injected interrupt opcode, T-state width/type,
// and opcodes also referenced by instdecode.
package mos6502_pkg;
  localparam int unsigned CYC_W = 3;
  localparam logic [7:0]  INT_OP = 8'h00;

  typedef logic [CYC_W-1:0] cycle_t;
  localparam cycle_t CYC_LAST = '1;

  localparam logic [7:0] OP_BRK     = 8'h00;
  localparam logic [7:0] OP_CLC     = 8'h18;
  localparam logic [7:0] OP_JMP_ABS = 8'h4C;
  localparam logic [7:0] OP_RTS     = 8'h60;
  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_INX     = 8'hE8;
  localparam logic [7:0] OP_NOP     = 8'hEA;
endpackage

// File: rtl/nmi_edge_det.sv
// Synchronous rising-edge detector; pulse_o is high for the one cycle where d_i
// is high and was low at the previous edge. Only built with INST_SEQ_NMI_EN.
module nmi_edge_det (
  input  logic clk,
  input  logic d_i,
  output logic pulse_o
);
  logic prev_q;

  // History just tracks the input every edge, which also makes reset load
  // the current level so a held-high line does not fire after reset.
  always_ff @(posedge clk) prev_q <= d_i;

  assign pulse_o = d_i & ~prev_q;
endmodule

// File: rtl/inst_sequencer.sv
// Instruction register and T-state sequencer feeding instdecode.
// Define INST_SEQ_NMI_EN to enable NMI edge detection and the nmi output.
module inst_sequencer
  import mos6502_pkg::*;
(
  input  logic             clk,
  input  logic             clr_n,
  input  logic [7:0]       dbus,
  input  logic             icyc,
  input  logic             rcyc,
  input  logic             scyc,
  input  logic             sinst,
  input  logic             irq_in,
  input  logic             nmi_in,
  input  logic             irq_dis,
  output logic [7:0]       inst,
  output logic [CYC_W-1:0] cycle,
  output logic             clr,
  output logic             irq,
  output logic             nmi,
  output logic             seq_err
);
  logic [7:0] inst_q, inst_d;
  cycle_t     cycle_q, cycle_d;
  logic       clr_q, clr_d, irq_q, irq_d, err_q, err_d;
  logic       nmi_q, nmi_pend_q;
  logic       nmi_rise, ack, inject;

`ifdef INST_SEQ_NMI_EN
  logic nmi_d, nmi_pend_d;

  nmi_edge_det u_nmi_det (
    .clk     (clk),
    .d_i     (nmi_in),
    .pulse_o (nmi_rise)
  );
`else
  logic unused_nmi_in;
  assign unused_nmi_in = nmi_in;
  assign nmi_rise      = 1'b0;
  assign nmi_q         = 1'b0;
  assign nmi_pend_q    = 1'b0;
`endif

  assign ack    = sinst && (cycle_q == '0) && (inst_q == INT_OP);
  assign inject = clr_q | nmi_pend_q | (irq_in & ~irq_dis);

  always_comb begin
    inst_d  = inst_q;
    cycle_d = cycle_q;
    clr_d   = clr_q;
    irq_d   = irq_q;
    err_d   = err_q;
`ifdef INST_SEQ_NMI_EN
    nmi_d      = nmi_q;
    nmi_pend_d = nmi_pend_q | nmi_rise;
`endif

    // Acknowledge retires the highest-priority request the decoder was shown.
    if (ack) begin
      if (clr_q) clr_d = 1'b0;
`ifdef INST_SEQ_NMI_EN
      else if (nmi_q) begin
        nmi_d      = 1'b0;
        nmi_pend_d = nmi_rise;
      end
`endif
      else irq_d = 1'b0;
    end

    if (rcyc) begin
      cycle_d = '0;
      inst_d  = inject ? INT_OP : dbus;
      irq_d   = irq_in & ~irq_dis & ~nmi_pend_q;
`ifdef INST_SEQ_NMI_EN
      nmi_d   = nmi_pend_q;
`endif
    end else if (scyc) begin
      cycle_d = cycle_q;
    end else if (icyc) begin
      if (cycle_q == CYC_LAST) begin
        cycle_d = '0;
        err_d   = 1'b1;
      end else begin
        cycle_d = cycle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      inst_q     <= INT_OP;
      cycle_q    <= '0;
      clr_q      <= 1'b1;
      irq_q      <= 1'b0;
      err_q      <= 1'b0;
`ifdef INST_SEQ_NMI_EN
      nmi_q      <= 1'b0;
      nmi_pend_q <= 1'b0;
`endif
    end else begin
      inst_q     <= inst_d;
      cycle_q    <= cycle_d;
      clr_q      <= clr_d;
      irq_q      <= irq_d;
      err_q      <= err_d;
`ifdef INST_SEQ_NMI_EN
      nmi_q      <= nmi_d;
      nmi_pend_q <= nmi_pend_d;
`endif
    end
  end

  assign inst    = inst_q;
  assign cycle   = cycle_q;
  assign clr     = clr_q;
  assign irq     = irq_q;
  assign nmi     = nmi_q;
  assign seq_err = err_q;
endmodule

// File: tb/tb_inst_sequencer.sv
// Directed scoreboard bench for inst_sequencer: each stepped edge pushes the
// hand-computed output snapshot, a negedge monitor pops and compares it.
module tb_inst_sequencer;
  import mos6502_pkg::*;

  logic       clk = 1'b0;
  logic       clr_n, icyc, rcyc, scyc, sinst, irq_in, nmi_in, irq_dis;
  logic [7:0] dbus;
  logic [7:0] inst;
  logic [2:0] cycle;
  logic       clr, irq, nmi, seq_err;

  typedef struct packed {
    logic [7:0] inst;
    logic [2:0] cycle;
    logic       clr;
    logic       irq;
    logic       nmi;
    logic       err;
  } snap_t;

  snap_t exp_s;
  snap_t sb_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  inst_sequencer dut (
    .clk(clk), .clr_n(clr_n), .dbus(dbus), .icyc(icyc), .rcyc(rcyc),
    .scyc(scyc), .sinst(sinst), .irq_in(irq_in), .nmi_in(nmi_in),
    .irq_dis(irq_dis), .inst(inst), .cycle(cycle), .clr(clr), .irq(irq),
    .nmi(nmi), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  // Monitor: registered outputs are compared mid-cycle against the scoreboard.
  initial begin : monitor
    snap_t e, a;
    string n;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n = name_q.pop_front();
        a = '{inst: inst, cycle: cycle, clr: clr, irq: irq, nmi: nmi, err: seq_err};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL %s: got inst=%h cyc=%0d clr=%b irq=%b nmi=%b err=%b, want inst=%h cyc=%0d clr=%b irq=%b nmi=%b err=%b",
                   n, a.inst, a.cycle, a.clr, a.irq, a.nmi, a.err,
                   e.inst, e.cycle, e.clr, e.irq, e.nmi, e.err);
        end
      end
    end
  end

  task automatic step(input string n, input logic r, input logic i,
                      input logic s, input logic si, input logic [7:0] d);
    rcyc = r; icyc = i; scyc = s; sinst = si; dbus = d;
    @(posedge clk);
    sb_q.push_back(exp_s);
    name_q.push_back(n);
    #1;
    rcyc = 0; icyc = 0; scyc = 0; sinst = 0;
  endtask

  task automatic icyc_n(input string n, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      exp_s.cycle = exp_s.cycle + 3'd1;
      if (exp_s.cycle == 3'd0) exp_s.err = 1'b1;
      step(n, 0, 1, 0, 0, 8'h00);
    end
  endtask

  initial begin
    clr_n = 0; icyc = 0; rcyc = 0; scyc = 0; sinst = 0;
    irq_in = 0; nmi_in = 0; irq_dis = 0; dbus = 8'h00;
    exp_s = '{inst: INT_OP, cycle: 3'd0, clr: 1'b1, irq: 1'b0, nmi: 1'b0, err: 1'b0};

    // Reset held two edges, then handoff.
    step("reset0", 0, 0, 0, 0, 8'h00);
    step("reset1", 0, 0, 0, 0, 8'h00);
    clr_n = 1;
    exp_s.clr = 0;
    step("clr_ack", 0, 0, 0, 1, 8'h00);
    icyc_n("icyc7", 7);
    exp_s.inst = OP_LDA_IMM; exp_s.cycle = 0;
    step("rcyc_lda", 1, 0, 0, 0, OP_LDA_IMM);

    // Normal sequencing: advance, stall, then rcyc beating icyc.
    icyc_n("icyc_a", 2);
    step("stall", 0, 1, 1, 0, 8'h00);
    exp_s.inst = OP_NOP; exp_s.cycle = 0;
    step("rcyc_icyc", 1, 1, 0, 0, OP_NOP);

    // Sinst on a non-interrupt opcode does nothing.
    step("sinst_ign", 0, 0, 0, 1, 8'h00);

    // IRQ masked, then unmasked, then acknowledged.
    irq_in = 1; irq_dis = 1;
    exp_s.inst = OP_INX;
    step("irq_masked", 1, 0, 0, 0, OP_INX);
    irq_dis = 0;
    exp_s.inst = INT_OP; exp_s.irq = 1;
    step("irq_inject", 1, 0, 0, 0, 8'h55);
    exp_s.irq = 0;
    step("irq_ack", 0, 0, 0, 1, 8'h00);
    irq_in = 0;
    exp_s.inst = OP_JMP_ABS;
    step("irq_dropped", 1, 0, 0, 0, OP_JMP_ABS);

    // Wrap fault is sticky across later instructions.
    icyc_n("wrap", 8);
    exp_s.inst = OP_RTS; exp_s.cycle = 0;
    step("err_sticky", 1, 0, 0, 0, OP_RTS);

`ifdef INST_SEQ_NMI_EN
    nmi_in = 1;
    step("nmi_edge", 0, 0, 0, 0, 8'h00);
    nmi_in = 0; irq_in = 1;
    exp_s.inst = INT_OP; exp_s.nmi = 1; exp_s.irq = 0;
    step("nmi_inject", 1, 0, 0, 0, 8'h77);
    exp_s.nmi = 0;
    step("nmi_ack", 0, 0, 0, 1, 8'h00);
    irq_in = 0;
    exp_s.inst = 8'h88;
    step("nmi_cleared", 1, 0, 0, 0, 8'h88);
`else
    nmi_in = 1;
    step("nmi_edge_off", 0, 0, 0, 0, 8'h00);
    nmi_in = 0;
    exp_s.inst = OP_CLC;
    step("nmi_off", 1, 0, 0, 0, OP_CLC);
`endif

    // Reset mid-instruction clears everything including the sticky fault.
    icyc_n("pre_reset", 2);
    clr_n = 0;
    exp_s = '{inst: INT_OP, cycle: 3'd0, clr: 1'b1, irq: 1'b0, nmi: 1'b0, err: 1'b0};
    step("reset_mid", 0, 1, 0, 0, 8'h00);
    clr_n = 1;
    exp_s.cycle = 1;
    step("post_reset", 0, 1, 0, 0, 8'h00);

    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clk);
    if (sb_q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, want 0", sb_q.size());
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
